// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator at the head of the IF stage.
// Produces the registered instruction-memory address and chip enable, with a
// flush/exception redirect at top priority and a one-entry buffer that holds a
// branch/jump resolved while IF is stalled until the stall is released.
// Optional build macro: PC_MISALIGN_CHECK_EN -- targets are loaded unmodified
// and if_misalign_o flags a loaded target that is not fetch-aligned. Without
// it, the low log2(FETCH_BYTES) bits of every loaded target are cleared.
module pc_gen #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
`ifdef PC_MISALIGN_CHECK_EN
  output logic              if_misalign_o,
`endif
  output logic [ADDR_W-1:0] if_pc_o,
  output logic              if_ce_o,
  output logic              if_redirect_o
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(FETCH_BYTES);
  // Low bits that must be zero for a fetch-aligned address are cleared by this mask.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - 1'b1);

  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redir_q, redir_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              mis_q, mis_d;

  // Only the IF stall bit matters here; the rest of the vector is for later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  function automatic logic [ADDR_W-1:0] fix_target(input logic [ADDR_W-1:0] t);
`ifdef PC_MISALIGN_CHECK_EN
    return t;
`else
    return t & ALIGN_MASK;
`endif
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
    return (t & ~ALIGN_MASK) != '0;
  endfunction

  // Next-state selection in redirect priority order: ce gate, flush, stall, live jump, pending jump, sequential.
  always_comb begin
    ce_d        = 1'b1;
    pc_d        = pc_q;
    redir_d     = 1'b0;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    mis_d       = mis_q;

    if (!ce_q) begin
      pc_d = RESET_VEC;
    end else if (flush_i) begin
      pc_d     = fix_target(flush_pc_i);
      pend_v_d = 1'b0;
      redir_d  = 1'b1;
      mis_d    = is_misaligned(flush_pc_i);
    end else if (stall[0]) begin
      // Hold the PC; remember the newest jump seen during the stall.
      if (jump_en_i) begin
        pend_v_d    = 1'b1;
        pend_addr_d = jump_addr_i;
      end
    end else if (jump_en_i) begin
      pc_d     = fix_target(jump_addr_i);
      pend_v_d = 1'b0;
      redir_d  = 1'b1;
      mis_d    = is_misaligned(jump_addr_i);
    end else if (pend_v_q) begin
      pc_d     = fix_target(pend_addr_q);
      pend_v_d = 1'b0;
      redir_d  = 1'b1;
      mis_d    = is_misaligned(pend_addr_q);
    end else begin
      // Sequential fetch wraps silently at the top of the address space.
      pc_d  = pc_q + STEP;
      mis_d = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q        <= 1'b0;
      pc_q        <= RESET_VEC;
      redir_q     <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      ce_q        <= ce_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      mis_q       <= mis_d;
    end
  end

  assign if_pc_o       = pc_q;
  assign if_ce_o       = ce_q;
  assign if_redirect_o = redir_q;

`ifdef PC_MISALIGN_CHECK_EN
  assign if_misalign_o = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with RESET_VEC=0xBFC0_0000 and
// 4-byte fetch, one with RESET_VEC=0 and 8-byte fetch for the wrap case.
module tb_pc_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_flush, a_jump;
  logic [5:0]  a_stall;
  logic [31:0] a_flush_pc, a_jump_addr, a_pc;
  logic        a_ce, a_redir;

  logic        b_rst, b_flush, b_jump;
  logic [5:0]  b_stall;
  logic [31:0] b_flush_pc, b_jump_addr, b_pc;
  logic        b_ce, b_redir;

`ifdef PC_MISALIGN_CHECK_EN
  logic a_mis, b_mis;
`endif

  int errors = 0;
  int checks = 0;

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'hBFC0_0000), .FETCH_BYTES(4)) u_a (
    .clk(clk), .rst(a_rst), .stall(a_stall),
    .flush_i(a_flush), .flush_pc_i(a_flush_pc),
    .jump_en_i(a_jump), .jump_addr_i(a_jump_addr),
`ifdef PC_MISALIGN_CHECK_EN
    .if_misalign_o(a_mis),
`endif
    .if_pc_o(a_pc), .if_ce_o(a_ce), .if_redirect_o(a_redir)
  );

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0000_0000), .FETCH_BYTES(8)) u_b (
    .clk(clk), .rst(b_rst), .stall(b_stall),
    .flush_i(b_flush), .flush_pc_i(b_flush_pc),
    .jump_en_i(b_jump), .jump_addr_i(b_jump_addr),
`ifdef PC_MISALIGN_CHECK_EN
    .if_misalign_o(b_mis),
`endif
    .if_pc_o(b_pc), .if_ce_o(b_ce), .if_redirect_o(b_redir)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] pc, input logic ce, input logic redir);
    chk({tag, ".pc"}, a_pc, pc);
    chk({tag, ".ce"}, {31'd0, a_ce}, {31'd0, ce});
    chk({tag, ".redir"}, {31'd0, a_redir}, {31'd0, redir});
  endtask

  initial begin
    a_rst = 1; a_stall = '0; a_flush = 0; a_flush_pc = '0; a_jump = 0; a_jump_addr = '0;
    b_rst = 1; b_stall = '0; b_flush = 0; b_flush_pc = '0; b_jump = 0; b_jump_addr = '0;

    // Reset held three cycles, then free-run from the reset vector.
    tick(); chk_a("rst1", 32'hBFC0_0000, 0, 0);
    tick(); tick(); chk_a("rst3", 32'hBFC0_0000, 0, 0);
    a_rst = 0;
    tick(); chk_a("rel", 32'hBFC0_0000, 1, 0);
    tick(); chk_a("seq1", 32'hBFC0_0004, 1, 0);
    tick(); chk_a("seq2", 32'hBFC0_0008, 1, 0);

    // Plain jump to 0x100.
    a_jump = 1; a_jump_addr = 32'h100;
    tick(); chk_a("jmp100", 32'h100, 1, 1);

    // Jump in first of three stall cycles.
    a_stall = 6'b000001; a_jump = 1; a_jump_addr = 32'h400;
    tick(); chk_a("stl1", 32'h100, 1, 0);
    a_jump = 0;
    tick(); tick(); chk_a("stl3", 32'h100, 1, 0);
    a_stall = '0;
    tick(); chk_a("pend400", 32'h400, 1, 1);
    tick(); chk_a("seq404", 32'h404, 1, 0);

    // Two jumps in one stall: newer wins.
    a_stall = 6'b000001; a_jump = 1; a_jump_addr = 32'h200;
    tick();
    a_jump_addr = 32'h300;
    tick();
    a_jump = 0;
    tick(); chk_a("stl2j", 32'h404, 1, 0);
    a_stall = '0;
    tick(); chk_a("pend300", 32'h300, 1, 1);

    // Live jump in release cycle beats pending 0x300.
    a_stall = 6'b000001; a_jump = 1; a_jump_addr = 32'h300;
    tick();
    a_stall = '0; a_jump_addr = 32'h500;
    tick(); chk_a("live500", 32'h500, 1, 1);
    a_jump = 0;
    tick(); chk_a("seq504", 32'h504, 1, 0);

    // Flush during stall with 0x400 pending.
    a_stall = 6'b000001; a_jump = 1; a_jump_addr = 32'h400;
    tick();
    a_jump = 0; a_flush = 1; a_flush_pc = 32'h8000_0180;
    tick(); chk_a("flush", 32'h8000_0180, 1, 1);
    a_flush = 0;
    tick(); chk_a("flhold", 32'h8000_0180, 1, 0);
    a_stall = '0;
    tick(); chk_a("flseq1", 32'h8000_0184, 1, 0);
    tick(); chk_a("flseq2", 32'h8000_0188, 1, 0);

    // Reset mid-stall with 0x400 pending.
    a_stall = 6'b000001; a_jump = 1; a_jump_addr = 32'h400;
    tick();
    a_jump = 0; a_rst = 1;
    tick(); chk_a("rstmid", 32'hBFC0_0000, 0, 0);
    a_rst = 0; a_stall = '0;
    tick(); chk_a("rstrel", 32'hBFC0_0000, 1, 0);
    tick(); chk_a("rstseq1", 32'hBFC0_0004, 1, 0);
    tick(); chk_a("rstseq2", 32'hBFC0_0008, 1, 0);

    // Misaligned jump target.
    a_jump = 1; a_jump_addr = 32'h402;
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    chk_a("mis402", 32'h402, 1, 1);
    chk("mis402.flag", {31'd0, a_mis}, 32'd1);
`else
    chk_a("aln402", 32'h400, 1, 1);
`endif
    a_jump = 0;
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    chk_a("mis406", 32'h406, 1, 0);
    chk("mis406.flag", {31'd0, a_mis}, 32'd0);
`else
    chk_a("aln404", 32'h404, 1, 0);
`endif

    // Misaligned flush target.
    a_flush = 1; a_flush_pc = 32'h8000_0183;
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    chk_a("flmis", 32'h8000_0183, 1, 1);
`else
    chk_a("flaln", 32'h8000_0180, 1, 1);
`endif
    a_flush = 0;

    // 8-byte fetch instance: wrap at top of address space.
    b_rst = 0;
    tick();
    chk("b.rel.pc", b_pc, 32'h0);
    chk("b.rel.ce", {31'd0, b_ce}, 32'd1);
    tick(); chk("b.seq8", b_pc, 32'h8);
    b_jump = 1; b_jump_addr = 32'hFFFF_FFF8;
    tick();
    chk("b.top", b_pc, 32'hFFFF_FFF8);
    chk("b.top.redir", {31'd0, b_redir}, 32'd1);
    b_jump = 0;
    tick();
    chk("b.wrap", b_pc, 32'h0);
    chk("b.wrap.redir", {31'd0, b_redir}, 32'd0);
    tick(); chk("b.after", b_pc, 32'h8);
    b_jump = 1; b_jump_addr = 32'h404;
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    chk("b.mis404", b_pc, 32'h404);
    chk("b.mis404.flag", {31'd0, b_mis}, 32'd1);
`else
    chk("b.aln404", b_pc, 32'h400);
`endif
    b_jump = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator at the head of the IF stage. Successor to the single-width PC register.
- Adds configurable address width, reset vector and fetch step.
- Adds a highest-priority flush/exception redirect and a one-entry pending-jump buffer, so a branch resolved during a stall is never lost.
- Drives the instruction-memory address and chip enable into IF.

Parameters:
- ADDR_W, 32, width of PC and all address ports.
- RESET_VEC, 32'h0000_0000 (truncated to ADDR_W), PC value held during and after reset.
- FETCH_BYTES, 4, sequential increment in bytes; legal values 4 or 8.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  6  pipeline stall vector; only bit 0 (IF stall) is used.
- flush_i  input  1  exception/eret redirect request.
- flush_pc_i  input  ADDR_W  flush target address.
- jump_en_i  input  1  ID-stage branch/jump request.
- jump_addr_i  input  ADDR_W  branch/jump target.
- if_pc_o  output  ADDR_W  current fetch address (registered).
- if_ce_o  output  1  instruction-memory chip enable (registered).
- if_redirect_o  output  1  registered; 1 for the cycle after if_pc_o was loaded from a non-sequential source.

Behaviour:
- Reset (rst=1 at an edge): if_ce_o<=0, if_pc_o<=RESET_VEC, pending_v<=0, if_redirect_o<=0. Applies regardless of any other input, including mid-stall or with a pending jump.
- if_ce_o: on any edge where rst=0, if_ce_o<=1. The first edge after reset release raises ce. if_pc_o stays RESET_VEC on that edge because ce was 0 before it.
- Internal state: pending_v (1 bit), pending_addr (ADDR_W).
- PC update priority, evaluated each edge with rst=0:
  1. if_ce_o==0: hold RESET_VEC.
  2. flush_i=1: load flush_pc_i even if stall[0]=1; clear pending_v; redirect<=1.
  3. stall[0]=1: hold if_pc_o. If jump_en_i=1, pending_v<=1 and pending_addr<=jump_addr_i; a newer jump overwrites an older pending one. redirect<=0.
  4. jump_en_i=1: load jump_addr_i; clear pending_v; redirect<=1. A live jump beats a pending one.
  5. pending_v=1: load pending_addr; clear pending_v; redirect<=1.
  6. Otherwise: if_pc_o <= if_pc_o + FETCH_BYTES, modulo 2^ADDR_W; redirect<=0.
- Wrap-around: an all-ones-aligned PC plus FETCH_BYTES wraps to 0 with no flag.
- Latency: every redirect appears on if_pc_o exactly one edge after it is accepted. A jump arriving during a stall appears one edge after stall[0] falls.
- Alignment, without the optional feature: the low log2(FETCH_BYTES) bits of any loaded target are forced to 0.
- if_redirect_o is 0 whenever if_ce_o is 0.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- When defined:
  - Targets are loaded unmodified.
  - Adds output if_misalign_o (1 bit, registered, reset 0). It is set on the edge that loads a target whose low log2(FETCH_BYTES) bits are non-zero, and cleared on the next load or increment.
  - Sequential increments never set it.
- When undefined:
  - No if_misalign_o port exists.
  - Low bits are forced to 0 as described under Behaviour.

Test Plan:
- Reset then free-run, RESET_VEC=0xBFC0_0000, FETCH_BYTES=4. Hold rst for 3 cycles, then release -> ce=0 while in reset. ce=1 one edge after release with pc=0xBFC0_0000. Following edges give 0xBFC0_0004, then 0xBFC0_0008.
- Jump during stall: pc=0x100, stall[0]=1 for 3 cycles, jump_en_i=1 with 0x400 in the first stall cycle only -> pc holds 0x100. One edge after stall falls, pc=0x400 and redirect=1. The next edge gives 0x404.
- Two jumps during one stall, to 0x200 then 0x300 -> after release pc=0x300. Live jump to 0x500 in the release cycle with 0x300 pending -> pc=0x500 and pending is discarded (next 0x504).
- Flush during stall and pending jump: pending 0x400, stall[0]=1, flush_i=1 with 0x8000_0180 -> next edge pc=0x8000_0180. After release pc=0x8000_0184, never 0x400.
- Wrap, ADDR_W=32, FETCH_BYTES=8: jump to 0xFFFF_FFF8 -> next increment gives 0x0000_0000.
- Reset mid-stall with pending 0x400 -> pc=RESET_VEC and ce=0. After release, sequential fetch from RESET_VEC; 0x400 is never issued.
- With PC_MISALIGN_CHECK_EN: jump to 0x402 -> pc=0x402 and if_misalign_o=1. Next increment: if_misalign_o=0. Without the macro: pc=0x400.
